led_bit_encoder: RTL



---
 rtl/led_enc_pkg.sv | 35 +++
 rtl/led_bit_timer.sv | 71 +++++++
 rtl/led_bit_encoder.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/led_enc_pkg.sv
// -----------------------------------------------------------------------------
// led_enc_pkg
//
// Shared definitions for the one-wire LED bit encoder:
//   - led_enc_state_e : encoder FSM state type (IDLE, SEND, STALL, LATCH)
//   - default 20 MHz timing constants (bit period, T0H, T1H, latch length)
//   - default pixel word width (24-bit GRB)
//   - led_sat_inc16   : saturating 16-bit increment used by the statistics
//                       counters
// -----------------------------------------------------------------------------
package led_enc_pkg;

  // Pixel word width: 8 bits each of G, R, B, shifted MSB first.
  localparam int LED_PIXEL_WIDTH    = 24;

  // Timing at 20 MHz: 1.25 us bit period, 0.4 us / 0.8 us high times,
  // 50 us latch low period.
  localparam int LED_BIT_CYCLES_20M = 25;
  localparam int LED_T0H_20M        = 8;
  localparam int LED_T1H_20M        = 16;
  localparam int LED_LATCH_20M      = 1000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_STALL = 2'd2,
    ST_LATCH = 2'd3
  } led_enc_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] led_sat_inc16(input logic [15:0] v);
    led_sat_inc16 = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/led_bit_timer.sv
// -----------------------------------------------------------------------------
// led_bit_timer
//
// Owns the within-bit cycle counter (bit_cnt) for the LED encoder and decides
// whether the serial line is in the high phase of the current bit.
//
// The level output is for the NEXT cycle: it is computed from the counter's
// next value and the next bit value, so the encoder can register it straight
// into led_sdi and have the line rise on the cycle after a pixel transfer.
//
// Ports:
//   clk, reset   - LED clock, synchronous active-high reset
//   start        - a new pixel is being loaded; counter restarts at 0
//   run          - encoder is in SEND this cycle; counter advances
//   active_next  - encoder will be in SEND next cycle
//   bit_next     - value of the bit being sent next cycle
//   level_next   - led_sdi value for the next cycle
//   bit_end      - this cycle is the last cycle of the current bit
// -----------------------------------------------------------------------------
module led_bit_timer
  import led_enc_pkg::*;
#(
  parameter int BIT_CYCLES = LED_BIT_CYCLES_20M,
  parameter int T0H_CYCLES = LED_T0H_20M,
  parameter int T1H_CYCLES = LED_T1H_20M
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic run,
  input  logic active_next,
  input  logic bit_next,
  output logic level_next,
  output logic bit_end
);

  localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] T0H_C    = CNT_W'(T0H_CYCLES);
  localparam logic [CNT_W-1:0] T1H_C    = CNT_W'(T1H_CYCLES);

  logic [CNT_W-1:0] bit_cnt_q;
  logic [CNT_W-1:0] bit_cnt_d;

  assign bit_end = run && (bit_cnt_q == CNT_LAST);

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    if (start) begin
      bit_cnt_d = '0;
    end else if (run) begin
      // Wrap at the end of each bit; leaving SEND also lands on 0, so the
      // counter is already parked for the next pixel.
      bit_cnt_d = bit_end ? '0 : bit_cnt_q + 1'b1;
    end
  end

  // High while the position within the bit is below the coded high time.
  always_comb begin
    level_next = active_next && (bit_cnt_d < (bit_next ? T1H_C : T0H_C));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt_q <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
    end
  end

endmodule

// File: rtl/led_bit_encoder.sv
// -----------------------------------------------------------------------------
// led_bit_encoder
//
// Per-string serializer: accepts 24-bit GRB pixel words over a valid/ready
// handshake and drives the one-wire LED waveform on led_sdi, MSB first, with
// T0H/T1H pulse-width coding. After the last pixel of a frame the line is held
// low for the latch period, then frame_done pulses.
//
// Optional build macro: LED_ENC_STATS_EN
//   defined   - frame_count / underrun_count are saturating 16-bit counters
//   undefined - both ports are constant zero
//
// Ports:
//   clk, reset      - 20 MHz LED clock, synchronous active-high reset
//   pixel_data      - pixel word
//   pixel_last      - pixel is the final one of the frame (sampled at transfer)
//   pixel_valid     - source offers a pixel
//   pixel_ready     - encoder accepts this cycle (combinational from state)
//   led_sdi         - registered serial LED data
//   busy            - high in any state except IDLE
//   underrun        - one-cycle pulse when a mid-frame pixel is missing
//   frame_done      - one-cycle pulse at the end of the latch period
//   frame_count     - saturating frame counter (stats build only)
//   underrun_count  - saturating underrun counter (stats build only)
// -----------------------------------------------------------------------------
module led_bit_encoder
  import led_enc_pkg::*;
#(
  parameter int PIXEL_WIDTH  = LED_PIXEL_WIDTH,
  parameter int BIT_CYCLES   = LED_BIT_CYCLES_20M,
  parameter int T0H_CYCLES   = LED_T0H_20M,
  parameter int T1H_CYCLES   = LED_T1H_20M,
  parameter int LATCH_CYCLES = LED_LATCH_20M
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [PIXEL_WIDTH-1:0] pixel_data,
  input  logic                   pixel_last,
  input  logic                   pixel_valid,
  output logic                   pixel_ready,
  output logic                   led_sdi,
  output logic                   busy,
  output logic                   underrun,
  output logic                   frame_done,
  output logic [15:0]            frame_count,
  output logic [15:0]            underrun_count
);

  if (!((T0H_CYCLES > 0) && (T0H_CYCLES < T1H_CYCLES) &&
        (T1H_CYCLES < BIT_CYCLES) && (LATCH_CYCLES >= 1))) begin : g_bad_timing
    $error("led_bit_encoder: need 0 < T0H < T1H < BIT_CYCLES and LATCH_CYCLES >= 1");
  end

  localparam int IDX_W = (PIXEL_WIDTH > 1) ? $clog2(PIXEL_WIDTH) : 1;
  localparam int LAT_W = $clog2(LATCH_CYCLES + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PIXEL_WIDTH - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LATCH_CYCLES - 1);

  led_enc_state_e         state_q, state_d;
  logic [PIXEL_WIDTH-1:0] shift_q, shift_d;
  logic                   last_q, last_d;
  logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
  logic [LAT_W-1:0]       latch_cnt_q, latch_cnt_d;
  logic                   led_sdi_q;
  logic                   underrun_q, underrun_d;
  logic                   frame_done_q, frame_done_d;

  logic load;
  logic xfer;
  logic final_bit;
  logic bit_end;
  logic level_next;

  assign final_bit = (bit_idx_q == IDX_LAST);

  // Ready is decoded from the current state so the source sees it in the same
  // cycle; in SEND it opens only for the very last cycle of a non-final pixel,
  // which lets the next pixel start with no idle cycle in between.
  always_comb begin
    pixel_ready = 1'b0;
    unique case (state_q)
      ST_IDLE:  pixel_ready = 1'b1;
      ST_STALL: pixel_ready = 1'b1;
      ST_SEND:  pixel_ready = bit_end && final_bit && !last_q;
      ST_LATCH: pixel_ready = 1'b0;
      default:  pixel_ready = 1'b0;
    endcase
  end

  assign xfer = pixel_valid && pixel_ready;

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    last_d       = last_q;
    bit_idx_d    = bit_idx_q;
    latch_cnt_d  = latch_cnt_q;
    underrun_d   = 1'b0;
    frame_done_d = 1'b0;
    load         = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_STALL: begin
        if (xfer) begin
          load = 1'b1;
        end
      end

      ST_SEND: begin
        if (bit_end) begin
          if (final_bit) begin
            if (last_q) begin
              state_d     = ST_LATCH;
              latch_cnt_d = '0;
            end else if (xfer) begin
              load = 1'b1;
            end else begin
              // Source ran dry mid-frame: flag it once and hold the line low.
              state_d    = ST_STALL;
              underrun_d = 1'b1;
            end
          end else begin
            shift_d   = shift_q << 1;
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end

      ST_LATCH: begin
        if (latch_cnt_q == LAT_LAST) begin
          state_d      = ST_IDLE;
          frame_done_d = 1'b1;
          latch_cnt_d  = '0;
        end else begin
          latch_cnt_d = latch_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (load) begin
      state_d   = ST_SEND;
      shift_d   = pixel_data;
      last_d    = pixel_last;
      bit_idx_d = '0;
    end
  end

  led_bit_timer #(
    .BIT_CYCLES (BIT_CYCLES),
    .T0H_CYCLES (T0H_CYCLES),
    .T1H_CYCLES (T1H_CYCLES)
  ) u_bit_timer (
    .clk         (clk),
    .reset       (reset),
    .start       (load),
    .run         (state_q == ST_SEND),
    .active_next (state_d == ST_SEND),
    .bit_next    (shift_d[PIXEL_WIDTH-1]),
    .level_next  (level_next),
    .bit_end     (bit_end)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      last_q       <= 1'b0;
      bit_idx_q    <= '0;
      latch_cnt_q  <= '0;
      led_sdi_q    <= 1'b0;
      underrun_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      last_q       <= last_d;
      bit_idx_q    <= bit_idx_d;
      latch_cnt_q  <= latch_cnt_d;
      led_sdi_q    <= level_next;
      underrun_q   <= underrun_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign led_sdi    = led_sdi_q;
  assign busy       = (state_q != ST_IDLE);
  assign underrun   = underrun_q;
  assign frame_done = frame_done_q;

`ifdef LED_ENC_STATS_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] underrun_cnt_q, underrun_cnt_d;

  // Counters advance on the same edge that raises the matching pulse.
  always_comb begin
    frame_cnt_d    = frame_done_d ? led_sat_inc16(frame_cnt_q)    : frame_cnt_q;
    underrun_cnt_d = underrun_d   ? led_sat_inc16(underrun_cnt_q) : underrun_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_q    <= '0;
      underrun_cnt_q <= '0;
    end else begin
      frame_cnt_q    <= frame_cnt_d;
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

  assign frame_count    = frame_cnt_q;
  assign underrun_count = underrun_cnt_q;
`else
  assign frame_count    = 16'h0000;
  assign underrun_count = 16'h0000;
`endif

endmodule
